dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencer and arbiter in front of the byte-wide data memory. Accepts load/store requests from two requesters: port 0 is the pipeline MEM stage, port 1 is the loader/debug port. It splits each word, half or byte access into one-byte memory beats, big-endian, and returns the assembled, extended read data. `busy` is the MEM-stage stall source.

## Interface
- `DEPTH`, 40: memory size in bytes.
- `AW`, 6: memory byte-address width, `2**AW >= DEPTH`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1: request valid, per port.
- `we0`, `we1` in 1: 1 = store, 0 = load.
- `size0`, `size1` in 2: access size; 01 word, 10 byte, 11 half, 00 illegal.
- `addr0`, `addr1` in 32: byte address.
- `wdata0`, `wdata1` in 32: store data, right-aligned.
- `gnt0`, `gnt1` out 1: request accepted this cycle (combinational).
- `done` out 1: one-cycle completion pulse.
- `done_id` out 1: port that owns `done`.
- `rdata` out 32: load result, valid with `done`.
- `err` out 1: access rejected, valid with `done`.
- `busy` out 1: transaction in flight.
- `mem_addr` out AW: byte address to memory.
- `mem_we` out 1: byte write enable.
- `mem_wdata` out 8: byte to write.
- `mem_rdata` in 8: combinational read byte for `mem_addr`.

## Operation
- FSM states: IDLE, XFER, DONE.
- **IDLE:** arbitrate among asserted `req`s.
  - If both are asserted, grant the port not granted last. The last-grant pointer resets to port 1, so port 0 wins first.
  - Assert `gnt` for the winner and latch its we/size/addr/wdata.
  - Set beat count N = 4 for word, 2 for half, 1 for byte. Clear `beat`. Go to XFER.
  - The requester drops `req` or presents its next request after `gnt`.
- **XFER:**
  - `mem_addr` = latched addr[AW-1:0] + `beat`, wrapping modulo 2^AW.
  - Stores: `mem_we` = 1.
    - Word: beat i drives `wdata[31-8i -: 8]`.
    - Half: beat 0 drives `wdata[15:8]`, beat 1 drives `wdata[7:0]`.
    - Byte: drives `wdata[7:0]`.
  - Loads: `rbuf` <= {`rbuf`[23:0], `mem_rdata`} at each beat's rising edge.
  - At beat N-1, go to DONE.
- **DONE:**
  - `done` = 1 and `done_id` = owner.
  - `rdata` extension:
    - Word: `rbuf`.
    - Half: sign-extend `rbuf[15:0]`.
    - Byte: sign-extend `rbuf[7:0]`.
    - Store: 0.
  - Go to IDLE. No arbitration happens in DONE.
- Illegal size 00: accepted, no beats (IDLE→DONE), `rdata` = 0, no memory write.
- Writes to addresses ≥ DEPTH are suppressed (`mem_we` forced 0). Reads there return 0.
- `busy` = (state != IDLE).
- Reset values: state IDLE, `gnt0`/`gnt1` 0, `done` 0, `done_id` 0, `rdata` 0, `err` 0, `busy` 0, `mem_addr` 0, `mem_we` 0, `mem_wdata` 0, `rbuf` 0.

## Timing
- `mem_*` outputs decode combinationally from registered state/beat/latch and are stable the whole beat. The memory's write edge falls inside the beat.
- Latency from `gnt` cycle k: beats in cycles k+1..k+N, `done` in cycle k+N+1.
  - Word: 6 cycles request-to-done. Half: 4. Byte: 3. Illegal: 2.
- Minimum back-to-back spacing is gnt, beats, done, gnt: one idle arbitration cycle per transaction.
- A `req` arriving while busy waits. Its `gnt` is not asserted until IDLE.
- Asynchronous reset mid-XFER aborts immediately. Bytes already written remain in memory; no `done` is issued.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A request is rejected if it is misaligned (word addr[1:0] != 0, half addr[0] != 0), has size 00, or has addr + N > DEPTH.
  - A rejected request goes IDLE→DONE with `err` = 1, `rdata` = 0, no memory beats.
- Not defined:
  - `err` is tied to 0.
  - Addresses are used modulo 2^AW, with the out-of-range suppression above.

## Structure
- Package `dmem_pkg`:
  - Size encodings: `SZ_WORD` = 2'b01, `SZ_BYTE` = 2'b10, `SZ_HALF` = 2'b11, `SZ_NONE` = 2'b00.
  - FSM state enum.
  - Beat-count function size→N.
- Sub-module `dmem_rr_arbiter`: 2-way round-robin with last-grant register and enable (IDLE only).

## Test plan
- Port 0 word store 0xDEADBEEF at addr 8, then word load at addr 8 → bytes 8..11 = DE,AD,BE,EF; `rdata` = 0xDEADBEEF; `done` 6 cycles after `req`.
- Byte load at addr 9 holding 0xAD → `rdata` = 0xFFFFFFAD. Half load at addr 10 holding 0x12,0x34 → `rdata` = 0x00001234.
- `req0` and `req1` both held continuously → grants alternate 0,1,0,1. First grant goes to port 0. `done_id` matches.
- Reset pulsed during beat 2 of a word store to addr 0 → bytes 0,1 updated, bytes 2,3 unchanged, no `done`. All outputs read 0 after reset.
- Store word to addr 38 (DEPTH 40) → bytes 38,39 written, beats 3,4 not written.
  - With `DMEM_ALIGN_CHECK_EN`: `err` = 1, no writes.
  - Same option, word load at addr 6 (misaligned): `err` = 1 after 2 cycles.
- Size 00 request → `done` 2 cycles after `req`, `rdata` = 0, `mem_we` never asserted.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Size encodings, FSM states and the size-to-beat-count mapping.
package dmem_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_HALF = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] beat_cnt(
    input logic [1:0] sz
  );
    logic [2:0] n;
    unique case (sz)
      SZ_WORD: n = 3'd4;
      SZ_HALF: n = 3'd2;
      SZ_BYTE: n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_arb.sv
// Two-way round-robin arbiter with last-grant pointer.
// Pointer resets to port 1 so port 0 wins the first contest.
module dmem_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic last_q;
  logic pick1;

  assign pick1  = req1_i & (~req0_i | ~last_q);
  assign gnt1_o = en_i & pick1;
  assign gnt0_o = en_i & req0_i & ~pick1;

  // remember which port won the last accepted grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (gnt0_o | gnt1_o) begin
      last_q <= gnt1_o;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Byte-beat sequencer/arbiter in front of the byte-wide data memory.
// Optional request rejection: define DMEM_ALIGN_CHECK_EN.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 40,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [1:0]    size0,
  input  logic [1:0]    size1,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done,
  output logic          done_id,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    n_q;
  logic [1:0]    beat_q;
  logic          owner_q;
  logic          err_q;
  logic [31:0]   rbuf_q;

  logic          sel_we;
  logic [1:0]    sel_size;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [2:0]    sel_n;
  logic          rej;
  logic          xfer;
  logic          last;
  logic          in_rng;
  logic [AW-1:0] mem_a;
  logic [2:0]    bidx;
  logic [31:0]   wsh;
  logic [7:0]    rd_byte;
  logic [31:0]   ext;

  dmem_rr_arbiter u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == IDLE),
    .req0_i (req0),
    .req1_i (req1),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_size  = gnt1 ? size1  : size0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;
  assign sel_n     = beat_cnt(sel_size);

`ifdef DMEM_ALIGN_CHECK_EN
  logic        mis;
  logic [32:0] end_a;
  assign mis = ((sel_size == SZ_WORD) & (sel_addr[1:0] != 2'b00))
             | ((sel_size == SZ_HALF) & sel_addr[0]);
  assign end_a = {1'b0, sel_addr} + {30'b0, sel_n};
  assign rej = mis
             | (sel_size == SZ_NONE)
             | (end_a > 33'(DEPTH));
`else
  logic unused_hi;
  assign unused_hi = ^sel_addr[31:AW];
  assign rej = 1'b0;
`endif

  assign xfer    = (state_q == XFER);
  assign mem_a   = addr_q + AW'(beat_q);
  assign in_rng  = {1'b0, mem_a} < DEPTH_L;
  assign last    = ({1'b0, beat_q} == (n_q - 3'd1));
  assign bidx    = n_q - 3'd1 - {1'b0, beat_q};
  assign wsh     = wdata_q >> {bidx[1:0], 3'b000};
  assign rd_byte = in_rng ? mem_rdata : 8'h00;

  assign mem_addr  = xfer ? mem_a : '0;
  assign mem_we    = xfer & we_q & in_rng;
  assign mem_wdata = xfer ? wsh[7:0] : 8'h00;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done & owner_q;
  assign err     = done & err_q;

  // extend the assembled read bytes by access size
  always_comb begin
    ext = 32'h0;
    unique case (size_q)
      SZ_WORD: ext = rbuf_q;
      SZ_HALF: ext = {{16{rbuf_q[15]}}, rbuf_q[15:0]};
      SZ_BYTE: ext = {{24{rbuf_q[7]}}, rbuf_q[7:0]};
      default: ext = 32'h0;
    endcase
  end

  assign rdata = (done & ~we_q & ~err_q) ? ext : 32'h0;

  // transaction FSM: latch winner, run beats, one-cycle done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_NONE;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      n_q     <= 3'd0;
      beat_q  <= 2'd0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      rbuf_q  <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt0 | gnt1) begin
            we_q    <= sel_we;
            size_q  <= sel_size;
            addr_q  <= sel_addr[AW-1:0];
            wdata_q <= sel_wdata;
            n_q     <= sel_n;
            beat_q  <= 2'd0;
            owner_q <= gnt1;
            err_q   <= rej;
            rbuf_q  <= 32'h0;
            if (rej || sel_n == 3'd0) begin
              state_q <= DONE;
            end else begin
              state_q <= XFER;
            end
          end
        end
        XFER: begin
          if (!we_q) begin
            rbuf_q <= {rbuf_q[23:0], rd_byte};
          end
          beat_q <= beat_q + 2'd1;
          if (last) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a byte memory model.
// Expectations follow DMEM_ALIGN_CHECK_EN when it is defined.
module tb_dmem_access_ctrl;

  localparam int DEPTH = 40;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [1:0]    size0, size1;
  logic [31:0]   addr0, addr1, wdata0, wdata1;
  logic          gnt0, gnt1, done, done_id, err, busy;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata, mem_rdata;

  logic [7:0] mem [0:DEPTH-1] = '{default: 8'h00};

  typedef struct {
    bit          id;
    logic [31:0] rd;
    bit          er;
    int          cy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   we_seen = 0;
  int   oob = 0;
  int   order [4];

  dmem_access_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .size0(size0), .size1(size1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done(done), .done_id(done_id),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (mem_we && int'(mem_addr) < DEPTH)
      mem[mem_addr] <= mem_wdata;

  assign mem_rdata = (int'(mem_addr) < DEPTH) ?
                     mem[mem_addr] : 8'h00;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endfunction

  // monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) we_seen++;
      if (mem_we && int'(mem_addr) >= DEPTH) oob++;
      if (done) begin
        if (q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_id", 32'(done_id), 32'(e.id));
          chk("rdata", rdata, e.rd);
          chk("err", 32'(err), 32'(e.er));
          chk("done_cycle", 32'(cyc), 32'(e.cy));
        end
      end
    end
  end

  task automatic drive(input bit p, input bit r,
                       input bit w, input logic [1:0] s,
                       input logic [31:0] a,
                       input logic [31:0] d);
    if (p) begin
      req1 = r; we1 = w; size1 = s;
      addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; size0 = s;
      addr0 = a; wdata0 = d;
    end
  endtask

  task automatic issue(input bit p, input bit w,
                       input logic [1:0] s,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [31:0] er,
                       input bit ee, input int lat);
    int t;
    exp_t e;
    @(negedge clk);
    drive(p, 1'b1, w, s, a, d);
    #1;
    t = 0;
    while (!(p ? gnt1 : gnt0) && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 50) begin
      chk("gnt_timeout", 32'd1, 32'd0);
      drive(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      return;
    end
    e.id = p; e.rd = er; e.er = ee; e.cy = cyc + lat;
    q.push_back(e);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk); t++;
    end
    if (t >= 50) chk("done_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int snap, t, ng;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #2;
    chk("rst_ctl", 32'({done, done_id, err, busy,
        mem_we, gnt0, gnt1}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    chk("rst_mwdata", 32'(mem_wdata), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(0, 1, 2'b01, 32'd8, 32'hDEADBEEF,
          32'h0, 0, 5);
    chk("mem8_word", {mem[8], mem[9], mem[10], mem[11]},
        32'hDEADBEEF);
    issue(0, 0, 2'b01, 32'd8, 32'h0,
          32'hDEADBEEF, 0, 5);
    issue(1, 0, 2'b10, 32'd9, 32'h0,
          32'hFFFFFFAD, 0, 2);
    issue(1, 1, 2'b11, 32'd10, 32'h00001234,
          32'h0, 0, 3);
    chk("mem10_half", {16'h0, mem[10], mem[11]},
        32'h00001234);
    issue(0, 0, 2'b11, 32'd10, 32'h0,
          32'h00001234, 0, 3);
`ifdef DMEM_ALIGN_CHECK_EN
    issue(0, 0, 2'b01, 32'd6, 32'h0, 32'h0, 1, 1);
`else
    issue(0, 0, 2'b01, 32'd6, 32'h0,
          32'h0000DEAD, 0, 5);
`endif
    snap = we_seen;
`ifdef DMEM_ALIGN_CHECK_EN
    issue(1, 1, 2'b00, 32'd4, 32'hFFFFFFFF,
          32'h0, 1, 1);
`else
    issue(1, 1, 2'b00, 32'd4, 32'hFFFFFFFF,
          32'h0, 0, 1);
`endif
    chk("sz0_no_we", 32'(we_seen - snap), 32'h0);
    chk("sz0_mem4", 32'(mem[4]), 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    issue(0, 1, 2'b01, 32'd38, 32'hCAFEF00D,
          32'h0, 1, 1);
    chk("oob_mem38", {16'h0, mem[38], mem[39]}, 32'h0);
`else
    issue(0, 1, 2'b01, 32'd38, 32'hCAFEF00D,
          32'h0, 0, 5);
    chk("oob_mem38", {16'h0, mem[38], mem[39]},
        32'h0000CAFE);
`endif
    chk("oob_we", 32'(oob), 32'h0);

    // abort a word store in beat 2 with reset
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'b01, 32'd0, 32'h11223344);
    #1;
    chk("abort_gnt", 32'(gnt0), 32'h1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ctl", 32'({done, done_id, err, busy,
        mem_we, gnt0, gnt1}), 32'h0);
    chk("abort_maddr", 32'(mem_addr), 32'h0);
    chk("abort_mwdata", 32'(mem_wdata), 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_mem0", {mem[0], mem[1], mem[2], mem[3]},
        32'h11220000);
    @(negedge clk);
    rst_n = 1'b1;

    // both ports requesting continuously
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'b10, 32'd9, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b10, 32'd8, 32'h0);
    ng = 0;
    t = 0;
    while (ng < 4 && t < 60) begin
      exp_t e;
      #1;
      if (gnt0 || gnt1) begin
        e.id = gnt1;
        e.rd = gnt1 ? 32'hFFFFFFDE : 32'hFFFFFFAD;
        e.er = 0;
        e.cy = cyc + 2;
        q.push_back(e);
        order[ng] = gnt1 ? 1 : 0;
        ng++;
      end
      if (ng == 4) begin
        @(posedge clk); #1;
      end else begin
        @(negedge clk);
      end
      t++;
    end
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("arb_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("arb_order%0d", i),
          32'(order[i]), 32'(i % 2));
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk); t++;
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
